// File: rtl/riscv_pkg.sv
// Shared core types: fetch entry layout, instruction constants and fetch state.
package riscv_pkg;

  localparam int unsigned CORE_XLEN = 32;

  localparam logic [31:0] INSTR_ZERO = 32'h0000_0000;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [CORE_XLEN-1:0] pc;
    logic [31:0]          instr;
    logic                 fault;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO of fetch entries with synchronous flush and occupancy count.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  fetch_entry_t           i_push_data,
  input  logic                   i_pop,
  output logic                   o_empty,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;

  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == (PW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~w_full | w_do_pop);
  assign o_head    = r_mem[r_rptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wptr] <= i_push_data;
  end

  // The request throttle upstream must never let a push meet a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(i_push && !i_flush && w_full && !i_pop));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, one-cycle imem tracking, redirect/fault
// handling and the buffered valid/ready interface toward decode.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned    XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned    BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [31:0]     imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] out_pc_o,
  output logic [31:0]     out_instr_o,
  output logic            out_fault_o
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic            r_s1_valid;
  logic [XLEN-1:0] r_s1_pc;
  logic            r_fault_pend;
  logic [XLEN-1:0] r_fault_pc;

  logic            w_empty;
  logic [CW-1:0]   w_count;
  fetch_entry_t    w_head;
  fetch_entry_t    w_push_entry;
  logic            w_push;
  logic            w_pop;
  logic [CW:0]     w_occ;
  logic            w_req;

  assign w_pop = out_valid_o & out_ready_i & ~redirect_i;

  // Occupancy once this cycle settles; a new request is only safe if its
  // response will still find a free slot next cycle.
  assign w_occ = {1'b0, w_count} + (CW+1)'(r_s1_valid) - (CW+1)'(w_pop);
  assign w_req = (r_state == FS_RUN) & ~redirect_i & (w_occ < (CW+1)'(BUF_DEPTH));

  assign imem_req_o  = w_req & ~reset;
  assign imem_addr_o = r_fetch_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= FS_RUN;
      r_fetch_pc   <= RESET_PC;
      r_s1_valid   <= 1'b0;
      r_s1_pc      <= '0;
      r_fault_pend <= 1'b0;
      r_fault_pc   <= '0;
    end else if (redirect_i) begin
      r_s1_valid <= 1'b0;
      r_fetch_pc <= redirect_pc_i;
      if (is_misaligned(redirect_pc_i[1:0])) begin
        r_state      <= FS_HALT;
        r_fault_pend <= 1'b1;
        r_fault_pc   <= redirect_pc_i;
      end else begin
        r_state      <= FS_RUN;
        r_fault_pend <= 1'b0;
      end
    end else begin
      r_fault_pend <= 1'b0;
      r_s1_valid   <= w_req;
      if (w_req) begin
        r_s1_pc    <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
    end
  end

  // A fault entry and a memory response never coincide: the redirect that
  // raises the fault also cancels the in-flight fetch.
  always_comb begin
    w_push_entry = '0;
    if (r_fault_pend) begin
      w_push_entry.pc    = CORE_XLEN'(r_fault_pc);
      w_push_entry.instr = INSTR_ZERO;
      w_push_entry.fault = 1'b1;
    end else begin
      w_push_entry.pc    = CORE_XLEN'(r_s1_pc);
      w_push_entry.instr = imem_rdata_i;
      w_push_entry.fault = 1'b0;
    end
  end

  assign w_push = ~redirect_i & (r_s1_valid | r_fault_pend);

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (redirect_i),
    .i_push      (w_push),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .o_empty     (w_empty),
    .o_head      (w_head),
    .o_count     (w_count)
  );

  assign out_valid_o = ~w_empty;
  assign out_pc_o    = out_valid_o ? XLEN'(w_head.pc) : '0;
  assign out_instr_o = out_valid_o ? w_head.instr     : INSTR_ZERO;
  assign out_fault_o = out_valid_o & w_head.fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-based reference model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_fetch_stage;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_fault;

  fetch_stage #(
    .XLEN      (XLEN),
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_pc_o      (out_pc),
    .out_instr_o   (out_instr),
    .out_fault_o   (out_fault)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } ent_t;

  ent_t        m_q[$];
  bit          m_inflight;
  logic [31:0] m_inflight_pc;
  logic [31:0] m_fpc;
  bit          m_halt;
  bit          m_fault_pend;
  logic [31:0] m_fault_pc;

  int checks = 0;
  int failures = 0;

  bit          prev_req;
  logic [31:0] prev_addr;

  logic        s_req, s_valid, s_fault;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_inflight   = 1'b0;
    m_fpc        = RST_PC;
    m_halt       = 1'b0;
    m_fault_pend = 1'b0;
    prev_req     = 1'b0;
  endtask

  // Entered right after a rising edge; asserts reset and checks the
  // immediate (asynchronous) effect, releases it just after the next edge.
  task automatic do_reset();
    reset     = 1'b1;
    out_ready = 1'b0;
    redirect  = 1'b0;
    #1;
    chk("rst_req",   imem_req,  0);
    chk("rst_addr",  imem_addr, RST_PC);
    chk("rst_valid", out_valid, 0);
    chk("rst_pc",    out_pc,    0);
    chk("rst_instr", out_instr, 0);
    chk("rst_fault", out_fault, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare against the model mid-cycle,
  // then advance the model across the rising edge.
  task automatic step(input bit rdy, input bit rd, input logic [31:0] rpc);
    bit          e_valid, e_req, pop;
    logic [31:0] e_pc, e_instr;
    bit          e_fault;
    int          occ;
    ent_t        e;

    out_ready   = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rdata  = prev_req ? mem(prev_addr) : 32'hDEAD_BEEF;

    e_valid = (m_q.size() > 0);
    e_pc    = e_valid ? m_q[0].pc    : 32'h0;
    e_instr = e_valid ? m_q[0].instr : 32'h0;
    e_fault = e_valid ? m_q[0].fault : 1'b0;
    pop     = e_valid && rdy && !rd;
    occ     = m_q.size() + int'(m_inflight) - int'(pop);
    e_req   = !m_halt && !rd && (occ < int'(DEPTH));

    @(negedge clk);
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = out_valid;
    s_pc    = out_pc;
    s_instr = out_instr;
    s_fault = out_fault;
    chk("req",   s_req,   e_req);
    if (e_req) chk("addr", s_addr, m_fpc);
    chk("valid", s_valid, e_valid);
    chk("pc",    s_pc,    e_pc);
    chk("instr", s_instr, e_instr);
    chk("fault", s_fault, e_fault);

    @(posedge clk);
    prev_req  = s_req;
    prev_addr = s_addr;
    if (rd) begin
      m_q.delete();
      m_inflight = 1'b0;
      m_fpc      = rpc;
      if (rpc[1:0] != 2'b00) begin
        m_halt       = 1'b1;
        m_fault_pend = 1'b1;
        m_fault_pc   = rpc;
      end else begin
        m_halt       = 1'b0;
        m_fault_pend = 1'b0;
      end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_inflight) begin
        e.pc = m_inflight_pc; e.instr = mem(m_inflight_pc); e.fault = 1'b0;
        m_q.push_back(e);
      end
      if (m_fault_pend) begin
        e.pc = m_fault_pc; e.instr = 32'h0; e.fault = 1'b1;
        m_q.push_back(e);
      end
      m_fault_pend = 1'b0;
      m_inflight   = e_req;
      if (e_req) begin
        m_inflight_pc = m_fpc;
        m_fpc         = m_fpc + 32'd4;
      end
    end
    #1;
  endtask

  initial begin
    bit          rdy, rd;
    logic [31:0] rpc;

    // Streaming from reset with decode always ready.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      step(1, 0, 0);
      if (c == 0) begin chk("first_req", s_req, 1); chk("first_addr", s_addr, 32'h0); end
      if (c == 1) chk("no_valid_c1", s_valid, 0);
      if (c == 2) begin chk("first_valid", s_valid, 1); chk("first_pc", s_pc, 32'h0); end
      if (c == 5) begin chk("c5_pc", s_pc, 32'hC); chk("c5_instr", s_instr, 32'd3); end
    end

    // Backpressure: buffer fills to BUF_DEPTH, requests stop, head holds.
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0);
      if (c >= 2) begin chk("bp_head_pc", s_pc, 32'h0); chk("bp_valid", s_valid, 1); end
      if (c == 4) chk("bp_req_off", s_req, 0);
    end
    for (int c = 0; c < 6; c++) begin
      step(1, 0, 0);
      if (c == 0) begin chk("resume_req", s_req, 1); chk("resume_addr", s_addr, 32'h8); end
      if (c == 1) chk("resume_pc1", s_pc, 32'h4);
      if (c == 2) chk("resume_pc2", s_pc, 32'h8);
    end

    // Aligned redirect with an entry buffered and a fetch in flight.
    step(0, 1, 32'h100);
    for (int c = 0; c < 4; c++) begin
      step(1, 0, 0);
      if (c == 0) begin chk("rd_req", s_req, 1); chk("rd_addr", s_addr, 32'h100); chk("rd_v0", s_valid, 0); end
      if (c == 1) chk("rd_v1", s_valid, 0);
      if (c == 2) begin
        chk("rd_first_pc", s_pc, 32'h100);
        chk("rd_first_instr", s_instr, 32'h40);
      end
    end

    // Misaligned redirect: one fault entry, then silence until next redirect.
    step(1, 1, 32'h102);
    for (int c = 0; c < 6; c++) begin
      step(c >= 2, 0, 0);
      if (c == 0) chk("mis_req0", s_req, 0);
      if (c == 1) begin
        chk("mis_pc", s_pc, 32'h102);
        chk("mis_fault", s_fault, 1);
        chk("mis_instr", s_instr, 32'h0);
      end
      if (c == 4) begin chk("halt_req", s_req, 0); chk("halt_valid", s_valid, 0); end
    end
    step(1, 1, 32'h200);
    step(1, 0, 0);
    chk("unhalt_addr", s_addr, 32'h200);
    for (int c = 0; c < 4; c++) step(1, 0, 0);

    // Redirect during a handshake, targeting the top of the address space.
    step(1, 1, 32'hFFFF_FFFC);
    for (int c = 0; c < 5; c++) begin
      step(1, 0, 0);
      if (c == 0) chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
      if (c == 1) chk("wrap_addr1", s_addr, 32'h0);
      if (c == 2) chk("wrap_pc", s_pc, 32'hFFFF_FFFC);
      if (c == 3) chk("wrapped_pc", s_pc, 32'h0);
    end

    // Reset mid-stream with entries buffered.
    step(0, 0, 0);
    step(0, 0, 0);
    do_reset();
    step(1, 0, 0);
    chk("restart_addr", s_addr, RST_PC);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) do_reset();
      rdy = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 99) < 4) || (m_halt && $urandom_range(0, 9) == 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: rpc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        6, 7:             rpc = {$urandom_range(0, 32'h3FFF_FFFF), 2'($urandom_range(1, 3))};
        8:                rpc = 32'hFFFF_FFF0 + {$urandom_range(0, 3), 2'b00};
        default:          rpc = 32'h100;
      endcase
      step(rdy, rd, rpc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
